ov7670_capture_ctrl: RTL
========================

# ov7670_capture_ctrl

Parametrised OV7670 pixel-capture controller sitting between the camera's parallel DVP bus (pclk domain) and the frame-buffer write port. It assembles 8-bit byte pairs into 16-bit pixels, and converts them according to a per-frame mode (RGB565, byte-swapped RGB565, YUV422-to-gray565). It applies configurable horizontal/vertical decimation and emits sequential write addresses clamped to the frame size. It tracks frame boundaries with a state machine and reports frame completion, frame count and byte-alignment errors.

## Interface
- IMG_W, 320, output pixels per line written to memory
- IMG_H, 240, output lines per frame written to memory
- H_DEC, 1, horizontal decimation: keep every H_DEC-th input pixel (1, 2 or 4)
- V_DEC, 1, vertical decimation: keep every V_DEC-th input line (1, 2 or 4)
- ADDR_W, 17, write-address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- pclk  in  1  camera pixel clock; sole clock
- reset  in  1  synchronous, active-high reset
- href  in  1  line-valid from camera
- vsync  in  1  frame sync from camera (high = blanking/sync)
- data  in  8  camera byte bus
- cap_en  in  1  capture enable, sampled at frame start
- mode  in  2  0 RGB565, 1 RGB565 byte-swapped, 2 YUV422→gray565, 3 reserved (treated as 0); latched at frame start
- we  out  1  memory write strobe, one cycle per pixel
- wAddr  out  ADDR_W  memory write address
- wData  out  16  memory write data
- frame_done  out  1  one-cycle pulse at end of a captured frame
- frame_ok  out  1  valid with frame_done: write count == IMG_W*IMG_H
- frame_cnt  out  8  captured-frame counter, wraps 255→0
- align_err  out  1  sticky: a line ended with an odd byte count; cleared at next frame start

## Operation
- Registered vsync_d/href_d provide edge detection; all decisions use sampled inputs at posedge pclk.
- States:
  - IDLE: after reset; go to SYNC when vsync=1.
  - SYNC: vsync high. On vsync falling edge, frame start: if cap_en=1 go to ACTIVE, else SKIP. Frame start latches mode and clears col, row, byte phase, write count and align_err.
  - ACTIVE: capture. On vsync rising edge, go to SYNC with frame_done=1 and frame_cnt+1.
  - SKIP: ignore data; on vsync rising edge go to SYNC with no frame_done.
- Byte pairing (ACTIVE, href=1): phase 0 stores the first byte in hi; phase 1 forms pixel {hi,data} and increments the input column.
- Line end (href falling edge in ACTIVE): if phase=1, set align_err. Then reset phase and column, and increment the input row.
- Pixel kept iff col%H_DEC==0, row%V_DEC==0, col/H_DEC<IMG_W, row/V_DEC<IMG_H, and write count < IMG_W*IMG_H.
- Conversion:
  - mode 0: {b0,b1}
  - mode 1: {b1,b0}
  - mode 2: Y=b1 (UYVY order, Y is the second byte), output {Y[7:3],Y[7:2],Y[7:3]}
- Address: the first kept pixel of a frame is written at wAddr=0; each subsequent kept pixel at +1. No write once the count reaches IMG_W*IMG_H (clamp, no wrap).
- Row/column counters saturate at their maxima and do not wrap; their widths are sized from IMG_W*H_DEC and IMG_H*V_DEC.
- href asserted while in SYNC/IDLE/SKIP is ignored.

## Timing
- Reset values: all outputs 0; state IDLE; internal counters and phase 0.
- Latency: the second byte sampled at edge k gives we=1 with valid wAddr/wData after edge k, held for exactly one cycle. we=0 on every other cycle.
- wAddr/wData hold their last value while we=0.
- frame_done/frame_ok/frame_cnt update on the edge that samples vsync 0→1 in ACTIVE. frame_done lasts one cycle; frame_ok and frame_cnt hold until the next frame_done.
- If a pixel completes on the same edge as the vsync rise, the write is still performed and counted in frame_ok.
- If href is still high when vsync rises, the line is closed as a line end (align check applies) before the transition to SYNC.
- cap_en or mode changes mid-frame have no effect until the next frame start.
- Reset asserted mid-frame: outputs return to 0 on the next edge; capture resumes only after a full vsync high→low.

## Test plan
- Reset, then IMG_W=4, IMG_H=2, H_DEC=V_DEC=1, mode 0, 2 lines of 8 bytes 0x00..0x0F → 8 writes, wAddr 0..7, first wData 0x0001, frame_done with frame_ok=1, frame_cnt=1.
- Same stimulus with mode 1 → first wData 0x0100; with mode 2 and byte pair (0x80,0xFF) → wData 0xFFFF.
- H_DEC=2, V_DEC=2, IMG_W=2, IMG_H=1, 4 lines of 4 pixels → writes only from line 0 pixels 0 and 2, wAddr 0,1, frame_ok=1.
- Line with 7 bytes → align_err=1 until the next vsync falling edge; the pixel count excludes the dangling byte.
- cap_en=0 at frame start, toggled to 1 mid-frame → no we and no frame_done that frame; the next frame captures normally.
- Frame with extra lines beyond IMG_H → writes stop at wAddr=IMG_W*IMG_H-1 with no wrap; reset mid-line → we=0 and state IDLE, no writes until a new vsync cycle.

Source files
------------

// File: rtl/ov7670_capture_ctrl.sv
// ov7670_capture_ctrl: OV7670 DVP byte-pair capture with per-frame format conversion,
// decimation and clamped sequential frame-buffer addressing.
module ov7670_capture_ctrl #(
   parameter int IMG_W  = 320,
   parameter int IMG_H  = 240,
   parameter int H_DEC  = 1,
   parameter int V_DEC  = 1,
   parameter int ADDR_W = 17
) (
   input  logic              pclk,
   input  logic              reset,
   input  logic              href,
   input  logic              vsync,
   input  logic [7:0]        data,
   input  logic              cap_en,
   input  logic [1:0]        mode,
   output logic              we,
   output logic [ADDR_W-1:0] wAddr,
   output logic [15:0]       wData,
   output logic              frame_done,
   output logic              frame_ok,
   output logic [7:0]        frame_cnt,
   output logic              align_err
);
   localparam int COL_MAX = IMG_W * H_DEC;
   localparam int ROW_MAX = IMG_H * V_DEC;
   localparam int CW = $clog2(COL_MAX + 1);
   localparam int RW = $clog2(ROW_MAX + 1);
   localparam int AW1 = ADDR_W + 1;
   localparam logic [CW-1:0] COL_LIM = CW'(COL_MAX);
   localparam logic [CW-1:0] COL_MSK = CW'(H_DEC - 1);
   localparam logic [RW-1:0] ROW_LIM = RW'(ROW_MAX);
   localparam logic [RW-1:0] ROW_MSK = RW'(V_DEC - 1);
   localparam logic [AW1-1:0] TOTAL = AW1'(IMG_W * IMG_H);

   typedef enum logic [1:0] {IDLE, SYNC, ACTIVE, SKIP} state_t;
   state_t state, state_n;

   logic           vsync_d, href_d, phase, phase_n;
   logic [7:0]     hi;
   logic [1:0]     mode_q;
   logic [CW-1:0]  col;
   logic [RW-1:0]  row;
   logic [AW1-1:0] wcnt, wcnt_n;
   logic           v_rise, v_fall, start, cap, pair, pix, line_end, keep, fin;
   logic [15:0]    pix_data;

   always_ff @(posedge pclk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:         if (vsync)  state_n = SYNC;
         SYNC:         if (v_fall) state_n = cap_en ? ACTIVE : SKIP;
         ACTIVE, SKIP: if (v_rise) state_n = SYNC;
         default:      state_n = IDLE;
      endcase
   end

   always_comb begin
      v_rise   = vsync & ~vsync_d;
      v_fall   = ~vsync & vsync_d;
      start    = (state == SYNC) && v_fall;
      cap      = state == ACTIVE;
      fin      = cap && v_rise;
      pair     = cap && href;
      pix      = pair && phase;
      phase_n  = pair ? ~phase : phase;
      // a line still open when the frame ends is closed here too
      line_end = cap && ((href_d && !href) || (href && v_rise));
      keep     = pix && ((col & COL_MSK) == '0) && ((row & ROW_MSK) == '0)
                 && (col < COL_LIM) && (row < ROW_LIM) && (wcnt < TOTAL);
      wcnt_n   = wcnt + AW1'(keep);
      pix_data = (mode_q == 2'd1) ? {data, hi} :
                 (mode_q == 2'd2) ? {data[7:3], data[7:2], data[7:3]} : {hi, data};
   end

   always_ff @(posedge pclk) begin
      if (reset) begin
         vsync_d    <= 1'b0;
         href_d     <= 1'b0;
         phase      <= 1'b0;
         hi         <= '0;
         mode_q     <= '0;
         col        <= '0;
         row        <= '0;
         wcnt       <= '0;
         we         <= 1'b0;
         wAddr      <= '0;
         wData      <= '0;
         frame_done <= 1'b0;
         frame_ok   <= 1'b0;
         frame_cnt  <= '0;
         align_err  <= 1'b0;
      end else begin
         vsync_d    <= vsync;
         href_d     <= href;
         we         <= keep;
         frame_done <= fin;
         wcnt       <= wcnt_n;
         phase      <= phase_n;
         if (pair && !phase) hi <= data;
         if (pix && col != COL_LIM) col <= col + 1'b1;
         if (keep) begin
            wAddr <= wcnt[ADDR_W-1:0];
            wData <= pix_data;
         end
         if (line_end) begin
            phase <= 1'b0;
            col   <= '0;
            if (row != ROW_LIM) row <= row + 1'b1;
            if (phase_n) align_err <= 1'b1;
         end
         if (fin) begin
            frame_ok  <= wcnt_n == TOTAL;
            frame_cnt <= frame_cnt + 8'd1;
         end
         if (start) begin
            mode_q    <= (mode == 2'd3) ? 2'd0 : mode;
            col       <= '0;
            row       <= '0;
            phase     <= 1'b0;
            wcnt      <= '0;
            align_err <= 1'b0;
         end
      end
   end
endmodule
